// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Four-entry (DEPTH) FIFO of pending doubleword stores between the MEM-stage
// pipeline and the byte-addressed data memory. Stores are accepted in one
// cycle. They drain to memory whenever the shared memory port is not used by a
// load. Loads are checked against every buffered store in the same cycle:
//   - An exact address match forwards the youngest matching data.
//   - A partial overlap stalls the load until the conflicting store drains.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   st_valid/addr/data store request from the pipeline
//   st_ready          buffer can accept a store (count before drain < DEPTH)
//   ld_valid/addr     load request from the pipeline
//   ld_fwd_hit/data   load satisfied from the buffer (youngest exact match)
//   ld_stall          load partially overlaps a buffered store
//   mem_adr/datain    address / write data to the data memory
//   mem_w, mem_r      memory write (drain) / read (load) enable
//   empty             no pending stores
// -----------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_fwd_hit,
  output logic [DATA_W-1:0] ld_fwd_data,
  output logic              ld_stall,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_datain,
  output logic              mem_w,
  output logic              mem_r,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Byte span of one doubleword; two accesses closer than this overlap.
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(DATA_W / 8);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [DEPTH-1:0] entry_valid;
  logic [DEPTH-1:0] entry_hit;
  logic [DEPTH-1:0] entry_overlap;

  logic             push;
  logic             drain;
  logic [PTR_W-1:0] fwd_idx;

  // ---------------------------------------------------------------------------
  // Per-entry address comparison. Validity is judged by the entry's distance
  // from head, so the comparison is independent of where the pointers sit.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    logic [PTR_W-1:0]  offset;
    logic [ADDR_W-1:0] diff_up;
    logic [ADDR_W-1:0] diff_down;
    logic              same;

    assign offset    = PTR_W'(i) - head;
    assign diff_up   = ld_addr - addr_mem[i];
    assign diff_down = addr_mem[i] - ld_addr;
    assign same      = (ld_addr == addr_mem[i]);

    assign entry_valid[i]   = CNT_W'(offset) < count;
    assign entry_hit[i]     = entry_valid[i] && same;
    // Modular differences catch overlaps that straddle the top of the address
    // space (e.g. a store at -4 and a load at 2).
    assign entry_overlap[i] = entry_valid[i] && !same &&
                              ((diff_up < SPAN) || (diff_down < SPAN));
  end

  // ---------------------------------------------------------------------------
  // Youngest matching entry: walk from oldest to youngest and keep the last hit.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    fwd_idx = head;
    for (int k = 0; k < DEPTH; k++) begin
      if (entry_hit[head + PTR_W'(k)]) fwd_idx = head + PTR_W'(k);
    end
  end

  // ---------------------------------------------------------------------------
  // Load resolution and memory-port arbitration.
  // ---------------------------------------------------------------------------
  always_comb begin
    st_ready    = (count != CNT_W'(DEPTH));
    empty       = (count == '0);
    push        = st_valid && st_ready;

    ld_stall    = ld_valid && (|entry_overlap);
    ld_fwd_hit  = ld_valid && !(|entry_overlap) && (|entry_hit);
    ld_fwd_data = ld_fwd_hit ? data_mem[fwd_idx] : '0;
    mem_r       = ld_valid && !ld_stall && !ld_fwd_hit;

    // A load that needs memory owns the port; otherwise the oldest store drains.
    drain       = !empty && !mem_r;
    mem_w       = drain;

    mem_adr     = '0;
    mem_datain  = '0;
    if (mem_r) begin
      mem_adr = ld_addr;
    end else if (drain) begin
      mem_adr    = addr_mem[head];
      mem_datain = data_mem[head];
    end
  end

  // ---------------------------------------------------------------------------
  // Pointer and occupancy state. Reset overrides any push or drain this cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)  tail <= tail + PTR_W'(1);
      if (drain) head <= head + PTR_W'(1);
      case ({push, drain})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the entry array has no reset; validity comes solely from head/count,
  // so stale contents are never observed and the storage stays plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= st_addr;
      data_mem[tail] <= st_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//
// Directed bench for store_buffer. A byte-addressed memory model captures
// drains on the rising edge and supplies load data combinationally. Inputs
// change 1 time unit after a rising edge; outputs are sampled 1 unit later.
// -----------------------------------------------------------------------------
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [63:0] st_addr;
  logic [63:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [63:0] ld_addr;
  logic        ld_fwd_hit;
  logic [63:0] ld_fwd_data;
  logic        ld_stall;
  logic [63:0] mem_adr;
  logic [63:0] mem_datain;
  logic        mem_w;
  logic        mem_r;
  logic        empty;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem_bytes [logic [63:0]];

  store_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .st_valid    (st_valid),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_ready    (st_ready),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_fwd_hit  (ld_fwd_hit),
    .ld_fwd_data (ld_fwd_data),
    .ld_stall    (ld_stall),
    .mem_adr     (mem_adr),
    .mem_datain  (mem_datain),
    .mem_w       (mem_w),
    .mem_r       (mem_r),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  // Little-endian doubleword write into the byte memory.
  always @(posedge clk) begin
    if (mem_w) begin
      for (int b = 0; b < 8; b++) mem_bytes[mem_adr + 64'(b)] = mem_datain[8*b +: 8];
    end
  end

  function automatic logic [63:0] mem_read(input logic [63:0] a);
    logic [63:0] v;
    v = '0;
    for (int b = 0; b < 8; b++) begin
      if (mem_bytes.exists(a + 64'(b))) v[8*b +: 8] = mem_bytes[a + 64'(b)];
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    st_valid = 1'b0;
    ld_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    ld_addr  = '0;
  endtask

  task automatic push_st(input logic [63:0] a, input logic [63:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic load(input logic [63:0] a);
    ld_valid = 1'b1;
    ld_addr  = a;
  endtask

  // Idles until the buffer reports empty, with a bounded cycle budget.
  task automatic wait_empty(input string name);
    int n;
    idle();
    n = 0;
    #1;
    while (!empty && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL %s: empty=%b after %0d cycles, required 1", name, empty, n);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle();
    reset = 1'b1;
    push_st(64'h10, 64'h1234);  // must be discarded by reset
    tick();
    reset = 1'b0;
    idle();
    #1;
    checks++;
    if ({st_ready, empty, mem_w, mem_r, ld_fwd_hit, ld_stall} !== 6'b110000) begin
      failures++;
      $display("FAIL reset_flags: got %b required 110000",
               {st_ready, empty, mem_w, mem_r, ld_fwd_hit, ld_stall});
    end
    checks++;
    if ({mem_adr, mem_datain} !== 128'h0) begin
      failures++;
      $display("FAIL reset_bus: adr=%h data=%h required 0", mem_adr, mem_datain);
    end
  endtask

  // Two consecutive stores drain in order with minimum latency.
  task automatic test_drain();
    push_st(64'h10, 64'hAAAA_AAAA_AAAA_AAAA);
    #1;
    checks++;
    if ({st_ready, mem_w} !== 2'b10) begin
      failures++;
      $display("FAIL drain_cycle0: st_ready,mem_w=%b required 10", {st_ready, mem_w});
    end
    tick();
    push_st(64'h18, 64'hBBBB_BBBB_BBBB_BBBB);
    #1;
    checks++;
    if ({mem_w, mem_adr, mem_datain} !== {1'b1, 64'h10, 64'hAAAA_AAAA_AAAA_AAAA}) begin
      failures++;
      $display("FAIL drain_first: w=%b adr=%h data=%h required 1/10/AA..", mem_w, mem_adr, mem_datain);
    end
    tick();
    idle();
    #1;
    checks++;
    if ({mem_w, mem_adr, mem_datain} !== {1'b1, 64'h18, 64'hBBBB_BBBB_BBBB_BBBB}) begin
      failures++;
      $display("FAIL drain_second: w=%b adr=%h data=%h required 1/18/BB..", mem_w, mem_adr, mem_datain);
    end
    tick();
    checks++;
    if ({empty, mem_w} !== 2'b10) begin
      failures++;
      $display("FAIL drain_done: empty,mem_w=%b required 10", {empty, mem_w});
    end
    checks++;
    if (mem_read(64'h10) !== 64'hAAAA_AAAA_AAAA_AAAA) begin
      failures++;
      $display("FAIL drain_mem: mem[10]=%h required AA..", mem_read(64'h10));
    end
  endtask

  // Fill while loads hold the port, refuse a 5th store, then drain in order.
  task automatic test_full();
    logic [63:0] exp_a [3];
    logic [63:0] exp_d [3];
    exp_a[0] = 64'h210; exp_d[0] = 64'h2222;
    exp_a[1] = 64'h218; exp_d[1] = 64'h3333;
    exp_a[2] = 64'h300; exp_d[2] = 64'hEEEE;
    load(64'h100);
    for (int k = 0; k < 4; k++) begin
      push_st(64'h200 + 64'(8 * k), 64'h1111 * 64'(k));
      tick();
    end
    push_st(64'h300, 64'hEEEE);
    #1;
    checks++;
    if ({st_ready, empty, mem_w, mem_r, mem_adr} !== {4'b0001, 64'h100}) begin
      failures++;
      $display("FAIL full_state: rdy,empty,w,r=%b adr=%h required 0001/100",
               {st_ready, empty, mem_w, mem_r}, mem_adr);
    end
    tick();                    // held store is ignored
    ld_valid = 1'b0;
    #1;
    checks++;
    if ({st_ready, mem_w, mem_adr} !== {2'b01, 64'h200}) begin
      failures++;
      $display("FAIL full_drain_refuse: rdy,w=%b adr=%h required 01/200", {st_ready, mem_w}, mem_adr);
    end
    tick();
    #1;
    checks++;
    if ({st_ready, mem_w, mem_adr, mem_datain} !== {2'b11, 64'h208, 64'h1111}) begin
      failures++;
      $display("FAIL full_accept: rdy,w=%b adr=%h data=%h required 11/208/1111",
               {st_ready, mem_w}, mem_adr, mem_datain);
    end
    tick();                    // push into wrapped slot while draining
    idle();
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({mem_w, mem_adr, mem_datain} !== {1'b1, exp_a[k], exp_d[k]}) begin
        failures++;
        $display("FAIL full_order[%0d]: w=%b adr=%h data=%h required 1/%h/%h",
                 k, mem_w, mem_adr, mem_datain, exp_a[k], exp_d[k]);
      end
      tick();
    end
    checks++;
    if ({empty, st_ready, mem_read(64'h300)} !== {2'b11, 64'hEEEE}) begin
      failures++;
      $display("FAIL full_end: empty,rdy=%b mem[300]=%h required 11/EEEE",
               {empty, st_ready}, mem_read(64'h300));
    end
  endtask

  // Youngest exact match forwards; a same-cycle push is invisible.
  task automatic test_forward();
    push_st(64'h60, 64'hD3);
    load(64'h60);
    #1;
    checks++;
    if ({ld_fwd_hit, ld_stall, mem_r, mem_adr} !== {3'b001, 64'h60}) begin
      failures++;
      $display("FAIL fwd_same_cycle: hit,stall,r=%b adr=%h required 001/60",
               {ld_fwd_hit, ld_stall, mem_r}, mem_adr);
    end
    tick();
    push_st(64'h40, 64'hD1);
    load(64'h100);
    tick();
    push_st(64'h40, 64'hD2);
    tick();
    st_valid = 1'b0;
    load(64'h40);
    #1;
    checks++;
    if ({ld_fwd_hit, ld_stall, mem_r, ld_fwd_data} !== {3'b100, 64'hD2}) begin
      failures++;
      $display("FAIL fwd_youngest: hit,stall,r=%b data=%h required 100/D2",
               {ld_fwd_hit, ld_stall, mem_r}, ld_fwd_data);
    end
    checks++;
    if ({mem_w, mem_adr} !== {1'b1, 64'h60}) begin
      failures++;
      $display("FAIL fwd_drain: w=%b adr=%h required 1/60", mem_w, mem_adr);
    end
    tick();
    load(64'h80);
    #1;
    checks++;
    if ({ld_fwd_hit, ld_stall, mem_r, mem_w, mem_adr} !== {4'b0010, 64'h80}) begin
      failures++;
      $display("FAIL fwd_miss: hit,stall,r,w=%b adr=%h required 0010/80",
               {ld_fwd_hit, ld_stall, mem_r, mem_w}, mem_adr);
    end
    tick();
    wait_empty("fwd_empty");
  endtask

  // Partial overlap stalls across two drains, then the load reads memory.
  task automatic test_stall();
    load(64'h100);
    push_st(64'h90, 64'h5555);
    tick();
    push_st(64'h80, 64'h0807_0605_0403_0201);
    tick();
    st_valid = 1'b0;
    load(64'h84);
    #1;
    checks++;
    if ({ld_stall, ld_fwd_hit, mem_r, mem_w, mem_adr} !== {4'b1001, 64'h90}) begin
      failures++;
      $display("FAIL stall_first: stall,hit,r,w=%b adr=%h required 1001/90",
               {ld_stall, ld_fwd_hit, mem_r, mem_w}, mem_adr);
    end
    tick();
    checks++;
    if ({ld_stall, mem_w, mem_adr} !== {2'b11, 64'h80}) begin
      failures++;
      $display("FAIL stall_second: stall,w=%b adr=%h required 11/80", {ld_stall, mem_w}, mem_adr);
    end
    tick();
    checks++;
    if ({ld_stall, mem_r, mem_w, mem_adr} !== {3'b010, 64'h84}) begin
      failures++;
      $display("FAIL stall_release: stall,r,w=%b adr=%h required 010/84",
               {ld_stall, mem_r, mem_w}, mem_adr);
    end
    checks++;
    if (mem_read(mem_adr) !== 64'h0000_0000_0807_0605) begin
      failures++;
      $display("FAIL stall_data: got %h required 0000000008070605", mem_read(mem_adr));
    end
    wait_empty("stall_empty");
  endtask

  // Overlap detection across the top of the address space, with exact-8 edges.
  task automatic test_wrap();
    load(64'h100);
    push_st(64'hFFFF_FFFF_FFFF_FFFC, 64'hD5);
    tick();
    st_valid = 1'b0;
    load(64'h4);
    #1;
    checks++;
    if ({ld_stall, mem_r, mem_adr} !== {2'b01, 64'h4}) begin
      failures++;
      $display("FAIL wrap_edge_up: stall,r=%b adr=%h required 01/4", {ld_stall, mem_r}, mem_adr);
    end
    load(64'hFFFF_FFFF_FFFF_FFF4);
    #1;
    checks++;
    if ({ld_stall, mem_r} !== 2'b01) begin
      failures++;
      $display("FAIL wrap_edge_down: stall,r=%b required 01", {ld_stall, mem_r});
    end
    load(64'h2);
    #1;
    checks++;
    if ({ld_stall, ld_fwd_hit, mem_r} !== 3'b100) begin
      failures++;
      $display("FAIL wrap_overlap: stall,hit,r=%b required 100", {ld_stall, ld_fwd_hit, mem_r});
    end
    tick();
    wait_empty("wrap_empty");
  endtask

  // Reset asserted while a drain is in progress discards pending stores.
  task automatic test_back_to_back();
    push_st(64'h500, 64'hF00D);
    tick();
    push_st(64'h508, 64'hBEEF);
    #1;
    checks++;
    if (mem_w !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre: mem_w=%b required 1", mem_w);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    #1;
    checks++;
    if ({st_ready, empty, mem_w, mem_r, ld_fwd_hit, ld_stall} !== 6'b110000) begin
      failures++;
      $display("FAIL rst_mid_post: got %b required 110000",
               {st_ready, empty, mem_w, mem_r, ld_fwd_hit, ld_stall});
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_drain();
    test_full();
    test_forward();
    test_stall();
    test_wrap();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
